md_sched: RTL and testbench

//   Multiply/divide scheduler for the 5-stage pipeline, living in the E stage.
//   - Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from E.
//   - Holds HI/LO and runs a multi-cycle busy countdown per operation.
//   - Drives md_stall, which freezes the D pipeline register and bubbles E.
//   - The top level wires D_REGen = ~(md_stall | other_stalls).

---
 rtl/md_sched.sv | 116 +++++++++++
 tb/tb_md_sched.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// Multiply/divide scheduler for the E stage: owns HI/LO, runs a fixed busy
// countdown per mult/div, and raises md_stall to hold dependent md ops in D.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_md_op,
  input  logic [31:0] E_rs,
  input  logic [31:0] E_rt,
  input  logic        D_uses_md,
  output logic [31:0] E_md_out,
  output logic        md_busy,
  output logic        md_stall
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q;
  logic [CW-1:0] count_q;
  logic [3:0]    op_q;
  logic [31:0]   rs_q, rt_q, hi_q, lo_q;

  logic        e_start, is_mul, smul, sdiv;
  logic [63:0] rs_ext, rt_ext, prod;
  logic        rs_neg, rt_neg;
  logic [31:0] rs_mag, rt_mag, rt_safe, quo_mag, rem_mag, quo, rem;

  assign e_start = (E_md_op >= OP_MULT) && (E_md_op <= OP_DIVU);
  assign is_mul  = (op_q == OP_MULT) || (op_q == OP_MULTU);
  assign smul    = (op_q == OP_MULT);
  assign sdiv    = (op_q == OP_DIV);

  // Sign-extending for mult makes the low 64 bits of the product the signed result.
  assign rs_ext = {{32{smul & rs_q[31]}}, rs_q};
  assign rt_ext = {{32{smul & rt_q[31]}}, rt_q};
  assign prod   = rs_ext * rt_ext;

  // Signed divide via magnitudes: 0x80000000 / -1 then wraps to 0x80000000, rem 0.
  assign rs_neg  = sdiv & rs_q[31];
  assign rt_neg  = sdiv & rt_q[31];
  assign rs_mag  = rs_neg ? (32'd0 - rs_q) : rs_q;
  assign rt_mag  = rt_neg ? (32'd0 - rt_q) : rt_q;
  assign rt_safe = (rt_mag == 32'd0) ? 32'd1 : rt_mag;
  assign quo_mag = rs_mag / rt_safe;
  assign rem_mag = rs_mag % rt_safe;
  assign quo     = (rs_neg ^ rt_neg) ? (32'd0 - quo_mag) : quo_mag;
  assign rem     = rs_neg ? (32'd0 - rem_mag) : rem_mag;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      op_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (e_start) begin
            op_q    <= E_md_op;
            rs_q    <= E_rs;
            rt_q    <= E_rt;
            count_q <= (E_md_op <= OP_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            state_q <= BUSY;
          end else if (E_md_op == OP_MTHI) begin
            hi_q <= E_rs;
          end else if (E_md_op == OP_MTLO) begin
            lo_q <= E_rs;
          end
        end
        BUSY: begin
          count_q <= count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_q <= IDLE;
            if (is_mul) begin
              {hi_q, lo_q} <= prod;
            end else if (rt_q != 32'd0) begin
              hi_q <= rem;
              lo_q <= quo;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign md_busy  = (state_q == BUSY);
  assign md_stall = D_uses_md & (md_busy | e_start);

  always_comb begin
    E_md_out = 32'd0;
    case (E_md_op)
      OP_MFHI: E_md_out = hi_q;
      OP_MFLO: E_md_out = lo_q;
      default: E_md_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: scoreboarded HI/LO results, busy/stall timing,
// divide-by-zero, reset mid-operation and operand latching.
module tb_md_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_md_op;
  logic [31:0] E_rs, E_rt;
  logic        D_uses_md;
  logic [31:0] E_md_out;
  logic        md_busy, md_stall;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [31:0] hi; logic [31:0] lo; } hilo_t;
  hilo_t sb[$];

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .E_md_op(E_md_op), .E_rs(E_rs), .E_rt(E_rt),
    .D_uses_md(D_uses_md), .E_md_out(E_md_out), .md_busy(md_busy), .md_stall(md_stall)
  );

  always #5 clk = ~clk;

  // Present a start op for one cycle; returns at the negedge of cycle t+1.
  task automatic start_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] ehi, input logic [31:0] elo);
    hilo_t e;
    @(negedge clk);
    E_md_op = op; E_rs = rs; E_rt = rt;
    e.hi = ehi; e.lo = elo;
    sb.push_back(e);
    @(negedge clk);
    E_md_op = 4'd0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (md_busy && cycles < 40) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    E_md_op = 4'd7; #1 hi = E_md_out;
    E_md_op = 4'd8; #1 lo = E_md_out;
    E_md_op = 4'd0; #1;
  endtask

  task automatic test_reset;
    logic [31:0] hi, lo;
    reset = 1'b1; E_md_op = 0; E_rs = 0; E_rt = 0; D_uses_md = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", md_busy); end
    checks++; if (md_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", md_stall); end
    read_hilo(hi, lo);
    checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL reset_hilo got=%h exp=0", {hi, lo}); end
    D_uses_md = 1'b0;
  endtask

  task automatic test_mult;
    logic [31:0] hi, lo; int c; hilo_t e;
    @(negedge clk);
    E_md_op = 4'd1; E_rs = 32'hFFFFFFFF; E_rt = 32'd2; #1;
    checks++; if (md_stall !== 1'b0) begin errors++; $display("FAIL mult_nostall got=%b exp=0", md_stall); end
    checks++; if (E_md_out !== 32'd0) begin errors++; $display("FAIL mdout_idle got=%h exp=0", E_md_out); end
    e.hi = 32'hFFFFFFFF; e.lo = 32'hFFFFFFFE; sb.push_back(e);
    @(negedge clk); E_md_op = 4'd0;
    wait_idle(c);
    checks++; if (c != 5) begin errors++; $display("FAIL mult_busy got=%0d exp=5", c); end
    read_hilo(hi, lo); e = sb.pop_front();
    checks++; if (hi !== e.hi || lo !== e.lo) begin errors++; $display("FAIL mult_res got=%h_%h exp=%h_%h", hi, lo, e.hi, e.lo); end
  endtask

  task automatic test_div;
    logic [31:0] hi, lo; int c; hilo_t e;
    start_op(4'd4, 32'd7, 32'd2, 32'd1, 32'd3);
    wait_idle(c);
    checks++; if (c != 10) begin errors++; $display("FAIL divu_busy got=%0d exp=10", c); end
    read_hilo(hi, lo); e = sb.pop_front();
    checks++; if (hi !== e.hi || lo !== e.lo) begin errors++; $display("FAIL divu_res got=%h_%h exp=%h_%h", hi, lo, e.hi, e.lo); end
    start_op(4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    wait_idle(c);
    read_hilo(hi, lo); e = sb.pop_front();
    checks++; if (hi !== e.hi || lo !== e.lo) begin errors++; $display("FAIL div_neg got=%h_%h exp=%h_%h", hi, lo, e.hi, e.lo); end
    start_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    wait_idle(c);
    read_hilo(hi, lo); e = sb.pop_front();
    checks++; if (hi !== e.hi || lo !== e.lo) begin errors++; $display("FAIL multu_max got=%h_%h exp=%h_%h", hi, lo, e.hi, e.lo); end
  endtask

  task automatic test_stall;
    logic [31:0] hi; int n; hilo_t e;
    @(negedge clk);
    E_md_op = 4'd1; E_rs = 32'h00010000; E_rt = 32'h00030000; D_uses_md = 1'b1; #1;
    checks++; if (md_stall !== 1'b1) begin errors++; $display("FAIL stall_start got=%b exp=1", md_stall); end
    e.hi = 32'd3; e.lo = 32'd0; sb.push_back(e);
    n = 1;
    @(negedge clk); E_md_op = 4'd0;
    while (md_stall && n < 40) begin n++; @(negedge clk); end
    checks++; if (n != 6) begin errors++; $display("FAIL stall_len got=%0d exp=6", n); end
    E_md_op = 4'd7; #1 hi = E_md_out; E_md_op = 4'd0; D_uses_md = 1'b0;
    e = sb.pop_front();
    checks++; if (hi !== e.hi) begin errors++; $display("FAIL stall_mfhi got=%h exp=%h", hi, e.hi); end
  endtask

  task automatic test_div_zero;
    logic [31:0] hi, lo; int c; hilo_t e;
    @(negedge clk); E_md_op = 4'd5; E_rs = 32'h1234;
    @(negedge clk); E_md_op = 4'd6; E_rs = 32'h5678;
    @(negedge clk); E_md_op = 4'd0;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL mt_busy got=%b exp=0", md_busy); end
    start_op(4'd3, 32'd5, 32'd0, 32'h1234, 32'h5678);
    wait_idle(c);
    checks++; if (c != 10) begin errors++; $display("FAIL div0_busy got=%0d exp=10", c); end
    read_hilo(hi, lo); e = sb.pop_front();
    checks++; if (hi !== e.hi || lo !== e.lo) begin errors++; $display("FAIL div0_res got=%h_%h exp=%h_%h", hi, lo, e.hi, e.lo); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] hi, lo;
    start_op(4'd2, 32'h00010000, 32'h00010000, 32'd0, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", md_busy); end
    repeat (8) @(negedge clk);
    read_hilo(hi, lo); void'(sb.pop_front());
    checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL rstmid_hilo got=%h exp=0", {hi, lo}); end
  endtask

  task automatic test_div_ovf;
    logic [31:0] hi, lo; int c; hilo_t e;
    start_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    E_rs = 32'd5; E_rt = 32'd1;
    wait_idle(c);
    read_hilo(hi, lo); e = sb.pop_front();
    checks++; if (hi !== e.hi || lo !== e.lo) begin errors++; $display("FAIL div_ovf got=%h_%h exp=%h_%h", hi, lo, e.hi, e.lo); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] hi, lo; int c; hilo_t e;
    start_op(4'd4, 32'd100, 32'd7, 32'd2, 32'd14);
    E_md_op = 4'd1; E_rs = 32'd9; E_rt = 32'd9;
    @(negedge clk); E_md_op = 4'd0;
    wait_idle(c);
    checks++; if (c != 9) begin errors++; $display("FAIL b2b_busy got=%0d exp=9", c); end
    read_hilo(hi, lo); e = sb.pop_front();
    checks++; if (hi !== e.hi || lo !== e.lo) begin errors++; $display("FAIL b2b_res got=%h_%h exp=%h_%h", hi, lo, e.hi, e.lo); end
  endtask

  initial begin
    fork
      begin
        test_reset;
        test_mult;
        test_div;
        test_stall;
        test_div_zero;
        test_reset_mid;
        test_div_ovf;
        test_back_to_back;
      end
      begin
        #50000;
        $display("FAIL timeout got=running exp=done");
        $fatal(1, "timeout");
      end
    join_any
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
